// File: rtl/ucup_mem_pkg.sv
// Shared types for the ucup memory arbiter: arbitration mode and port-ID sizing.
package ucup_mem_pkg;

   typedef enum logic [0:0] {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   // A single port still needs one ID bit so the FIFO has a non-zero width.
   function automatic int unsigned port_id_width(input int unsigned num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

endpackage

// File: rtl/ucup_id_fifo.sv
// In-order FIFO of port IDs for accepted requests; the head names the port that owns
// the next downstream response.
module ucup_id_fifo #(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 1,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             pop_i,
   output logic [Width-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CntW-1:0]  count_o
);

   localparam int unsigned      PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrW-1:0]  LastPtr  = PtrW'(Depth - 1);
   localparam logic [CntW-1:0]  DepthCnt = CntW'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push;
   logic             do_pop;

   // Depth need not be a power of two, so wrap explicitly.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == DepthCnt);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push_i && !full_o;
      do_pop   = pop_i && !empty_o;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/ucup_mem_arbiter.sv
// N-to-1 memory request arbiter (round-robin or fixed priority) with in-order response
// routing back to the requesting port and a sticky orphan-response flag.
module ucup_mem_arbiter
   import ucup_mem_pkg::*;
#(
   parameter int unsigned NumPorts       = 2,
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned MaxOutstanding = 4,
   parameter arb_mode_e   ArbMode        = ARB_RR,
   localparam int unsigned BeWidth       = DataWidth / 8,
   localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
   input  logic                          clk_sys_i,
   input  logic                          rst_sys_ni,
   input  logic [NumPorts-1:0]           host_req_i,
   input  logic [NumPorts-1:0]           host_we_i,
   input  logic [NumPorts*BeWidth-1:0]   host_be_i,
   input  logic [NumPorts*AddrWidth-1:0] host_addr_i,
   input  logic [NumPorts*DataWidth-1:0] host_wdata_i,
   output logic [NumPorts-1:0]           host_gnt_o,
   output logic [NumPorts-1:0]           host_rvalid_o,
   output logic [NumPorts*DataWidth-1:0] host_rdata_o,
   output logic                          mem_req_o,
   output logic                          mem_we_o,
   output logic [BeWidth-1:0]            mem_be_o,
   output logic [AddrWidth-1:0]          mem_addr_o,
   output logic [DataWidth-1:0]          mem_wdata_o,
   input  logic                          mem_gnt_i,
   input  logic                          mem_rvalid_i,
   input  logic [DataWidth-1:0]          mem_rdata_i,
   output logic [CntW-1:0]               outstanding_o,
   output logic                          err_o
);

   localparam int unsigned IdW = port_id_width(NumPorts);

   logic [IdW-1:0] prio_ptr;
   logic [IdW-1:0] win_id;
   logic [IdW-1:0] win_lo;
   logic [IdW-1:0] win_hi;
   logic           found_lo;
   logic           found_hi;
   logic           any_req;
   logic           handshake;
   logic           fifo_full;
   logic           fifo_empty;
   logic [IdW-1:0] head_id;
   logic           err_q, err_d;

   // win_hi is the first requester at or above the pointer; win_lo the first overall,
   // used when nothing at or above the pointer requests. Fixed mode pins the pointer to 0.
   always_comb begin
      win_lo   = '0;
      win_hi   = '0;
      found_lo = 1'b0;
      found_hi = 1'b0;
      for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
         if (host_req_i[i]) begin
            win_lo   = IdW'(i);
            found_lo = 1'b1;
            if (i >= int'(prio_ptr)) begin
               win_hi   = IdW'(i);
               found_hi = 1'b1;
            end
         end
      end
      any_req = found_lo;
      win_id  = found_hi ? win_hi : win_lo;
   end

   // A full ID FIFO stalls the request even if a response pops it this cycle.
   assign mem_req_o = any_req && !fifo_full;
   assign handshake = mem_req_o && mem_gnt_i;

   always_comb begin
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      host_gnt_o  = '0;
      for (int i = 0; i < int'(NumPorts); i++) begin
         if (win_id == IdW'(i)) begin
            mem_we_o      = host_we_i[i];
            mem_be_o      = host_be_i[i*BeWidth +: BeWidth];
            mem_addr_o    = host_addr_i[i*AddrWidth +: AddrWidth];
            mem_wdata_o   = host_wdata_i[i*DataWidth +: DataWidth];
            host_gnt_o[i] = handshake;
         end
      end
   end

   always_comb begin
      host_rvalid_o = '0;
      host_rdata_o  = '0;
      for (int i = 0; i < int'(NumPorts); i++) begin
         if (!fifo_empty && (head_id == IdW'(i))) begin
            host_rvalid_o[i]                         = mem_rvalid_i;
            host_rdata_o[i*DataWidth +: DataWidth]   = mem_rdata_i;
         end
      end
      err_d = err_q | (mem_rvalid_i && fifo_empty);
   end

   ucup_id_fifo #(
      .Depth (MaxOutstanding),
      .Width (IdW)
   ) u_id_fifo (
      .clk_i   (clk_sys_i),
      .rst_ni  (rst_sys_ni),
      .push_i  (handshake),
      .data_i  (win_id),
      .pop_i   (mem_rvalid_i),
      .data_o  (head_id),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (outstanding_o)
   );

   if (ArbMode == ARB_RR) begin : g_rr
      logic [IdW-1:0] rr_ptr_q, rr_ptr_d;

      always_comb begin
         rr_ptr_d = rr_ptr_q;
         if (handshake) begin
            rr_ptr_d = (win_id == IdW'(NumPorts - 1)) ? '0 : win_id + 1'b1;
         end
      end

      always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
         if (!rst_sys_ni) begin
            rr_ptr_q <= '0;
         end else begin
            rr_ptr_q <= rr_ptr_d;
         end
      end

      assign prio_ptr = rr_ptr_q;
   end else begin : g_fixed
      assign prio_ptr = '0;
   end

   always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
      if (!rst_sys_ni) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;

endmodule

// File: tb/tb_ucup_mem_arbiter.sv
// Bench for ucup_mem_arbiter: a round-robin and a fixed-priority instance share stimulus;
// a port-ID queue predicts grant order, response routing and the outstanding count.
module tb_ucup_mem_arbiter;
   import ucup_mem_pkg::*;

   localparam int NP = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MO = 4;
   localparam int BW = DW / 8;
   localparam int CW = $clog2(MO + 1);
   localparam int IW = 1;

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [NP-1:0]    host_req, host_we;
   logic [NP*BW-1:0] host_be;
   logic [NP*AW-1:0] host_addr;
   logic [NP*DW-1:0] host_wdata;
   logic             mem_gnt, mem_rvalid;
   logic [DW-1:0]    mem_rdata;

   logic [NP-1:0]    rr_gnt, rr_rvalid, fx_gnt, fx_rvalid;
   logic [NP*DW-1:0] rr_rdata, fx_rdata;
   logic             rr_mreq, rr_mwe, fx_mreq, fx_mwe;
   logic [BW-1:0]    rr_mbe, fx_mbe;
   logic [AW-1:0]    rr_maddr, fx_maddr;
   logic [DW-1:0]    rr_mwdata, fx_mwdata;
   logic [CW-1:0]    rr_out, fx_out;
   logic             rr_err, fx_err;

   ucup_mem_arbiter #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW),
                      .MaxOutstanding(MO), .ArbMode(ARB_RR)) dut_rr (
      .clk_sys_i(clk), .rst_sys_ni(rst_n),
      .host_req_i(host_req), .host_we_i(host_we), .host_be_i(host_be),
      .host_addr_i(host_addr), .host_wdata_i(host_wdata),
      .host_gnt_o(rr_gnt), .host_rvalid_o(rr_rvalid), .host_rdata_o(rr_rdata),
      .mem_req_o(rr_mreq), .mem_we_o(rr_mwe), .mem_be_o(rr_mbe),
      .mem_addr_o(rr_maddr), .mem_wdata_o(rr_mwdata),
      .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
      .outstanding_o(rr_out), .err_o(rr_err)
   );

   ucup_mem_arbiter #(.NumPorts(NP), .AddrWidth(AW), .DataWidth(DW),
                      .MaxOutstanding(MO), .ArbMode(ARB_FIXED)) dut_fx (
      .clk_sys_i(clk), .rst_sys_ni(rst_n),
      .host_req_i(host_req), .host_we_i(host_we), .host_be_i(host_be),
      .host_addr_i(host_addr), .host_wdata_i(host_wdata),
      .host_gnt_o(fx_gnt), .host_rvalid_o(fx_rvalid), .host_rdata_o(fx_rdata),
      .mem_req_o(fx_mreq), .mem_we_o(fx_mwe), .mem_be_o(fx_mbe),
      .mem_addr_o(fx_maddr), .mem_wdata_o(fx_mwdata),
      .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
      .outstanding_o(fx_out), .err_o(fx_err)
   );

   // scoreboard: port IDs of accepted requests, oldest first
   logic [IW-1:0] exp_q[$];
   int            m_ptr;
   logic          m_err;
   int            vec_cnt;
   int            err_cnt;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Called at posedge+1: drive one cycle, check combinational outputs, update the model,
   // then check registered outputs after the edge. Returns at the next posedge+1.
   task automatic step(input logic [NP-1:0] req, input logic gnt, input logic rv,
                       input logic fx_chk);
      int            w;
      bit            found;
      bit            mreq;
      logic [DW-1:0] rd;
      logic [NP-1:0] exp_rv;
      rd         = $urandom;
      host_req   = req;
      host_we    = NP'($urandom_range(0, 3));
      host_be    = (NP*BW)'($urandom);
      host_addr  = {$urandom, $urandom};
      host_wdata = {$urandom, $urandom};
      mem_gnt    = gnt;
      mem_rvalid = rv;
      mem_rdata  = rd;
      #3;
      mreq  = (req != '0) && (exp_q.size() < MO);
      w     = 0;
      found = 1'b0;
      for (int k = 0; k < NP; k++) begin
         int p;
         p = (m_ptr + k) % NP;
         if (!found && req[p]) begin
            w     = p;
            found = 1'b1;
         end
      end
      check("mem_req", rr_mreq, mreq);
      check("gnt", rr_gnt, (mreq && gnt) ? (1 << w) : 0);
      if (mreq) begin
         check("mem_addr", rr_maddr, host_addr[w*AW +: AW]);
         check("mem_we", rr_mwe, host_we[w]);
         check("mem_wdata", rr_mwdata, host_wdata[w*DW +: DW]);
      end
      exp_rv = '0;
      if (rv && exp_q.size() > 0) exp_rv[exp_q[0]] = 1'b1;
      check("rvalid", rr_rvalid, exp_rv);
      if (rv && exp_q.size() > 0) check("rdata", rr_rdata[exp_q[0]*DW +: DW], rd);
      if (fx_chk) begin
         check("fx_gnt", fx_gnt, (mreq && gnt) ? 2'b01 : 2'b00);
         check("fx_rvalid", fx_rvalid, (rv && exp_q.size() > 0) ? 2'b01 : 2'b00);
      end
      if (rv) begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         else m_err = 1'b1;
      end
      if (mreq && gnt) begin
         exp_q.push_back(IW'(w));
         m_ptr = (w + 1) % NP;
      end
      @(posedge clk);
      #1;
      check("outstanding", rr_out, exp_q.size());
      check("err", rr_err, m_err);
      check("fx_outstanding", fx_out, exp_q.size());
      check("fx_err", fx_err, m_err);
   endtask

   task automatic drain(input logic fx_chk);
      for (int g = 0; g < 2 * MO && exp_q.size() > 0; g++) step('0, 1'b1, 1'b1, fx_chk);
      check("drained", exp_q.size(), 0);
   endtask

   task automatic do_reset();
      host_req   = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      rst_n      = 1'b0;
      #1;
      exp_q.delete();
      m_ptr = 0;
      m_err = 1'b0;
      check("rst_outstanding", rr_out, 0);
      check("rst_err", rr_err, 0);
      check("rst_fx_outstanding", fx_out, 0);
      check("rst_fx_err", fx_err, 0);
      check("rst_mem_req", rr_mreq, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      host_req   = '0;
      host_we    = '0;
      host_be    = '0;
      host_addr  = '0;
      host_wdata = '0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      vec_cnt    = 0;
      err_cnt    = 0;
      m_ptr      = 0;
      m_err      = 1'b0;
      #1;
      do_reset();
      step('0, 1'b1, 1'b0, 1'b0);

      // both ports request: alternating grants; from cycle 2 push and pop at count 2
      for (int c = 0; c < 8; c++) step(2'b11, 1'b1, 1'(c >= 2), 1'b0);
      drain(1'b0);

      // no responses: four grants, then stall; a pop does not relieve the same cycle
      for (int c = 0; c < 6; c++) step(2'b11, 1'b1, 1'b0, 1'b0);
      step(2'b11, 1'b1, 1'b1, 1'b0);
      step(2'b11, 1'b1, 1'b0, 1'b0);
      drain(1'b0);

      // random traffic, downstream back-pressure, FIFO wrap
      for (int c = 0; c < 80; c++)
         step(NP'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
              1'(exp_q.size() > 0 && $urandom_range(0, 1) != 0), 1'b0);
      drain(1'b0);

      // orphan response: dropped, sticky error
      step('0, 1'b1, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0, 1'b0);
      step(2'b10, 1'b1, 1'b0, 1'b0);
      step('0, 1'b1, 1'b1, 1'b0);
      do_reset();

      // fixed priority: port 0 every cycle, port 1 starved
      for (int c = 0; c < 6; c++) step(2'b11, 1'b1, 1'(c >= 2), 1'b1);
      drain(1'b1);

      // reset with three in flight; late responses are orphans; pointer back at port 0
      for (int c = 0; c < 3; c++) step(2'b11, 1'b1, 1'b0, 1'b0);
      do_reset();
      for (int c = 0; c < 3; c++) step('0, 1'b1, 1'b1, 1'b0);
      step(2'b11, 1'b1, 1'b0, 1'b0);
      drain(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
